// File: rtl/ok_ep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ok_ep_pkg
//  Description : Shared FrontPanel endpoint definitions for the pipe-out
//                serializer: pipe word width, endpoint addresses and the
//                serializer state encoding.
//  Contents    : OK_WORD_W       - okPipeOut ep_datain width
//                TRIG_OUT_DONE   - okTriggerOut address carrying ready_trig
//                PIPE_OUT_RESULT - okPipeOut address carrying pipe_data
//                pipe_state_e    - IDLE / READY / SEND
//  Revision    : 1.0 - initial release
// ============================================================================
package ok_ep_pkg;

  localparam int         OK_WORD_W       = 32;
  localparam logic [7:0] TRIG_OUT_DONE   = 8'h60;
  localparam logic [7:0] PIPE_OUT_RESULT = 8'hA0;

  // IDLE : no payload held
  // READY: payload loaded, no word taken yet
  // SEND : at least one word taken, more remain
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_SEND  = 2'd2
  } pipe_state_e;

endpackage : ok_ep_pkg
`default_nettype wire

// File: rtl/pipe_word_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_word_mux
//  Description : Combinational word selector. Returns word idx_i of the
//                payload, word k being payload_i[k*WORD_W +: WORD_W].
//                An index past the last word yields zero.
//  Ports       : payload_i  in  DATA_W  held payload
//                idx_i      in  IDX_W   word index
//                word_o     out WORD_W  selected word
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_word_mux #(
  parameter int DATA_W = 128,
  parameter int WORD_W = 32,
  parameter int IDX_W  = 2
) (
  input  logic [DATA_W-1:0] payload_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [WORD_W-1:0] word_o
);

  localparam int NWORDS = DATA_W / WORD_W;

  always_comb begin
    word_o = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (idx_i == IDX_W'(k)) begin
        word_o = payload_i[k*WORD_W +: WORD_W];
      end
    end
  end

endmodule : pipe_word_mux
`default_nettype wire

// File: rtl/pipeout_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : pipeout_serializer
//  Description : Captures a wide payload on a load pulse and streams it to an
//                okPipeOut endpoint (PIPE_OUT_RESULT) as WORD_W words, least
//                significant first. pipe_data always pre-fetches the word the
//                host takes next. ready_trig drives bit 0 of the TRIG_OUT_DONE
//                trigger; overrun/underrun are sticky status flags for a
//                wire-out status register.
//  Ports       : clk         in   okClk, posedge
//                rst         in   asynchronous, active-high
//                load        in   capture din (pulse)
//                din         in   DATA_W payload
//                pipe_read   in   okPipeOut ep_read
//                pipe_data   out  okPipeOut ep_datain (registered)
//                ready_trig  out  one-cycle payload-ready pulse
//                busy        out  payload held, not fully read
//                words_left  out  unread words in current payload
//                overrun     out  sticky: load dropped while busy
//                underrun    out  sticky: read with no word available
//                clr_flags   in   clear overrun/underrun (set wins)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeout_serializer
  import ok_ep_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int WORD_W = OK_WORD_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [DATA_W-1:0]                  din,
  input  logic                               pipe_read,
  output logic [WORD_W-1:0]                  pipe_data,
  output logic                               ready_trig,
  output logic                               busy,
  output logic [$clog2(DATA_W/WORD_W+1)-1:0] words_left,
  output logic                               overrun,
  output logic                               underrun,
  input  logic                               clr_flags
);

  localparam int NWORDS = DATA_W / WORD_W;
  localparam int IDX_W  = $clog2(NWORDS);
  localparam int WL_W   = $clog2(NWORDS + 1);
  localparam logic [WL_W-1:0] WL_FULL = WL_W'(NWORDS);

  pipe_state_e       state_q,      state_d;
  logic [DATA_W-1:0] payload_q,    payload_d;
  logic [IDX_W-1:0]  idx_q,        idx_d;
  logic [WORD_W-1:0] pipe_data_q,  pipe_data_d;
  logic              ready_trig_q, ready_trig_d;
  logic [WL_W-1:0]   words_left_q, words_left_d;
  logic              overrun_q,    overrun_d;
  logic              underrun_q,   underrun_d;

  logic [IDX_W-1:0]  idx_next;
  logic [WORD_W-1:0] word_next;
  logic              holding;
  logic              read_ok;
  logic              last_read;
  logic              load_ok;

  assign idx_next = idx_q + IDX_W'(1);

  // Word after the one currently on pipe_data, ready for the pre-fetch.
  pipe_word_mux #(
    .DATA_W (DATA_W),
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_word_mux (
    .payload_i (payload_q),
    .idx_i     (idx_next),
    .word_o    (word_next)
  );

  assign holding   = (state_q != ST_IDLE);
  assign read_ok   = holding && pipe_read;
  assign last_read = read_ok && (words_left_q == WL_W'(1));
  // A load is taken when nothing is held, or when the final word is being
  // read in the same cycle (back-to-back payloads).
  assign load_ok   = load && (!holding || last_read);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      payload_q    <= '0;
      idx_q        <= '0;
      pipe_data_q  <= '0;
      ready_trig_q <= 1'b0;
      words_left_q <= '0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      payload_q    <= payload_d;
      idx_q        <= idx_d;
      pipe_data_q  <= pipe_data_d;
      ready_trig_q <= ready_trig_d;
      words_left_q <= words_left_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    payload_d    = payload_q;
    idx_d        = idx_q;
    pipe_data_d  = pipe_data_q;
    words_left_d = words_left_q;
    ready_trig_d = load_ok;

    // Sticky flags: a new event in the same cycle as a clear wins.
    overrun_d  = (overrun_q  && !clr_flags) || (load && !load_ok);
    underrun_d = (underrun_q && !clr_flags) || (pipe_read && !holding);

    if (load_ok) begin
      state_d      = ST_READY;
      payload_d    = din;
      idx_d        = '0;
      pipe_data_d  = din[WORD_W-1:0];
      words_left_d = WL_FULL;
    end else begin
      unique case (state_q)
        ST_READY, ST_SEND: begin
          if (last_read) begin
            state_d      = ST_IDLE;
            idx_d        = '0;
            pipe_data_d  = '0;
            words_left_d = '0;
          end else if (read_ok) begin
            state_d      = ST_SEND;
            idx_d        = idx_next;
            pipe_data_d  = word_next;
            words_left_d = words_left_q - WL_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign pipe_data  = pipe_data_q;
  assign ready_trig = ready_trig_q;
  assign busy       = holding;
  assign words_left = words_left_q;
  assign overrun    = overrun_q;
  assign underrun   = underrun_q;

endmodule : pipeout_serializer
`default_nettype wire

// File: tb/tb_pipeout_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeout_serializer
//  Description : Directed, table-driven bench for pipeout_serializer with a
//                128-bit instance and a 64-bit instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeout_serializer;

  localparam logic [127:0] D1 = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
  localparam logic [127:0] D2 = 128'h0000_0008_0000_0007_0000_0006_0000_0005;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [127:0] din;
  logic         pipe_read;
  logic         clr_flags;
  logic [31:0]  pipe_data;
  logic         ready_trig;
  logic         busy;
  logic [2:0]   words_left;
  logic         overrun;
  logic         underrun;

  logic         load64;
  logic [63:0]  din64;
  logic         read64;
  logic [31:0]  pd64;
  logic         trig64;
  logic         busy64;
  logic [1:0]   wl64;
  logic         ov64;
  logic         un64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeout_serializer #(.DATA_W(128), .WORD_W(32)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .din        (din),
    .pipe_read  (pipe_read),
    .pipe_data  (pipe_data),
    .ready_trig (ready_trig),
    .busy       (busy),
    .words_left (words_left),
    .overrun    (overrun),
    .underrun   (underrun),
    .clr_flags  (clr_flags)
  );

  pipeout_serializer #(.DATA_W(64), .WORD_W(32)) u_dut64 (
    .clk        (clk),
    .rst        (rst),
    .load       (load64),
    .din        (din64),
    .pipe_read  (read64),
    .pipe_data  (pd64),
    .ready_trig (trig64),
    .busy       (busy64),
    .words_left (wl64),
    .overrun    (ov64),
    .underrun   (un64),
    .clr_flags  (1'b0)
  );

  typedef struct {
    logic         ld;
    logic [127:0] d;
    logic         rd;
    logic         clr;
    logic [31:0]  pd;
    logic         trig;
    logic         bsy;
    logic [2:0]   wl;
    logic         ov;
    logic         un;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", nm, id, act, exp);
    end
  endtask

  task automatic check_all(input int id, input logic [31:0] pd, input logic trig, input logic bsy,
                           input logic [2:0] wl, input logic ov, input logic un);
    chk("pipe_data",  id, pipe_data,         pd);
    chk("ready_trig", id, 32'(ready_trig),   32'(trig));
    chk("busy",       id, 32'(busy),         32'(bsy));
    chk("words_left", id, 32'(words_left),   32'(wl));
    chk("overrun",    id, 32'(overrun),      32'(ov));
    chk("underrun",   id, 32'(underrun),     32'(un));
  endtask

  // Drive one cycle of inputs at the falling edge, return after the rising edge.
  task automatic step(input logic ld, input logic [127:0] d, input logic rd, input logic clr);
    @(negedge clk);
    load = ld; din = d; pipe_read = rd; clr_flags = clr;
    @(posedge clk);
    #1;
    load = 1'b0; pipe_read = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic step64(input logic ld, input logic [63:0] d, input logic rd);
    @(negedge clk);
    load64 = ld; din64 = d; read64 = rd;
    @(posedge clk);
    #1;
    load64 = 1'b0; read64 = 1'b0;
  endtask

  initial begin
    //            ld  din   rd   clr   pd      trig bsy wl    ov   un
    // Full payload read out, words 1..4, then idle
    vq.push_back('{1'b1, D1, 1'b0, 1'b0, 32'd1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0});
    vq.push_back('{1'b0, D2, 1'b1, 1'b0, 32'd2, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0});
    vq.push_back('{1'b0, D2, 1'b1, 1'b0, 32'd3, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0});
    vq.push_back('{1'b0, D2, 1'b1, 1'b0, 32'd4, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0});
    vq.push_back('{1'b0, D2, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
    vq.push_back('{1'b0, D2, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
    // Load while busy mid-stream: dropped, overrun, old payload continues
    vq.push_back('{1'b1, D1, 1'b0, 1'b0, 32'd1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0});
    vq.push_back('{1'b0, D2, 1'b1, 1'b0, 32'd2, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0});
    vq.push_back('{1'b0, D2, 1'b1, 1'b0, 32'd3, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0});
    vq.push_back('{1'b1, D2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0});
    vq.push_back('{1'b0, D2, 1'b1, 1'b0, 32'd4, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0});
    vq.push_back('{1'b0, D2, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0});
    vq.push_back('{1'b0, D2, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
    // Back-to-back: load together with read of last word
    vq.push_back('{1'b1, D1, 1'b0, 1'b0, 32'd1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0});
    vq.push_back('{1'b0, D2, 1'b1, 1'b0, 32'd2, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0});
    vq.push_back('{1'b0, D2, 1'b1, 1'b0, 32'd3, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0});
    vq.push_back('{1'b0, D2, 1'b1, 1'b0, 32'd4, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0});
    vq.push_back('{1'b1, D2, 1'b1, 1'b0, 32'd5, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0});
    vq.push_back('{1'b0, D1, 1'b1, 1'b0, 32'd6, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0});
    vq.push_back('{1'b0, D1, 1'b1, 1'b0, 32'd7, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0});
    vq.push_back('{1'b0, D1, 1'b1, 1'b0, 32'd8, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0});
    vq.push_back('{1'b0, D1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
    // Underrun, clear, set-wins-over-clear, load+read in idle
    vq.push_back('{1'b0, D1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1});
    vq.push_back('{1'b0, D1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
    vq.push_back('{1'b0, D1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1});
    vq.push_back('{1'b0, D1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
    vq.push_back('{1'b1, D2, 1'b1, 1'b0, 32'd5, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1});
    vq.push_back('{1'b1, D1, 1'b0, 1'b1, 32'd5, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0});
    vq.push_back('{1'b0, D1, 1'b0, 1'b1, 32'd5, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0});

    rst = 1'b1; load = 1'b0; din = '0; pipe_read = 1'b0; clr_flags = 1'b0;
    load64 = 1'b0; din64 = '0; read64 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all(-1, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].ld, vq[i].d, vq[i].rd, vq[i].clr);
      check_all(i, vq[i].pd, vq[i].trig, vq[i].bsy, vq[i].wl, vq[i].ov, vq[i].un);
    end

    // Reset mid-stream: two reads of D2, then asynchronous reset between edges
    step(1'b0, '0, 1'b1, 1'b0);
    check_all(100, 32'd6, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_all(101, 32'd7, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all(102, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, D1, 1'b0, 1'b0);
    check_all(103, 32'd1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_all(104, 32'd2, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);

    // 64-bit build: two words
    step64(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    chk("dut64 pipe_data",  200, pd64,         32'hCCCC_DDDD);
    chk("dut64 ready_trig", 200, 32'(trig64), 32'd1);
    chk("dut64 words_left", 200, 32'(wl64),   32'd2);
    step64(1'b0, '0, 1'b1);
    chk("dut64 pipe_data",  201, pd64,         32'hAAAA_BBBB);
    chk("dut64 words_left", 201, 32'(wl64),   32'd1);
    step64(1'b0, '0, 1'b1);
    chk("dut64 pipe_data",  202, pd64,         32'h0);
    chk("dut64 busy",       202, 32'(busy64), 32'd0);
    chk("dut64 underrun",   202, 32'(un64),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pipeout_serializer
`default_nettype wire
